ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_array.sv | 33 +++
 rtl/ram_responder.sv | 162 ++++++++++++++++
 tb/tb_ram_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/ram_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Latency: write lands at the clock edge; read data is valid one cycle after the address edge.
// Backpressure: none, one access slot per cycle; contents are never reset.
module ram_array
    import ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // Byte-masked write and read sampled on the same edge (read returns the pre-write word).
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < STRB_W; k++) begin
            if (i_we && i_wstrb[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Single-outstanding memory responder: latches a CE-qualified request, waits, then pulses done.
// Latency: oRAM_DONE is high in the cycle after edge N+1+LATENCY, where edge N accepted the request.
// Backpressure: initiator holds iRAM_CE until done; a held CE parks in HOLD so it never re-triggers.
module ram_responder
    import ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iRAM_CE,
    input  logic              iRAM_RD,
    input  logic              iRAM_WR,
    input  logic [STRB_W-1:0] iRAM_WSTRB,
    input  logic [31:0]       iRAM_ADDR,
    input  logic [WORD_W-1:0] iRAM_DATA,
    output logic [WORD_W-1:0] oRAM_DATA,
    output logic              oRAM_DONE,
    output logic              oRAM_ERR
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_strb;
    logic              r_rd;
    logic              r_wr;

    logic [WORD_W-1:0] r_data;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_strb;
    logic              w_rd;
    logic              w_wr;
    logic              w_err;
    logic              w_enter_resp;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_rdata;

    // In IDLE the access fields come straight from the pins so a zero-latency access can hit
    // the array on its accept edge; everywhere else the latched copy is used.
    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_strb  = r_strb;
        w_rd    = r_rd;
        w_wr    = r_wr;
        if (r_state == ST_IDLE) begin
            w_addr  = iRAM_ADDR;
            w_wdata = iRAM_DATA;
            w_strb  = iRAM_WSTRB;
            w_rd    = iRAM_RD;
            w_wr    = iRAM_WR;
        end
    end

    assign w_err        = (w_addr >= LIMIT) || (w_rd == w_wr);
    assign w_enter_resp = !iRST && (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
    assign w_mem_we     = w_enter_resp && w_wr && !w_err;

    // Next-state and countdown logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (iRAM_CE) begin
                    if (LATENCY > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 4'(LATENCY - 1);
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = iRAM_CE ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!iRAM_CE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset wins over any request on the same edge.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request on the accept edge; later pin activity is ignored.
    always_ff @(posedge iCLK) begin
        if (!iRST && r_state == ST_IDLE && iRAM_CE) begin
            r_addr  <= iRAM_ADDR;
            r_wdata <= iRAM_DATA;
            r_strb  <= iRAM_WSTRB;
            r_rd    <= iRAM_RD;
            r_wr    <= iRAM_WR;
        end
    end

    // Response registers: done/err pulse as RESP is left; read data is held until the next read.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else if (r_state == ST_RESP) begin
            r_done <= 1'b1;
            r_err  <= w_err;
            if (w_rd) begin
                r_data <= w_err ? '0 : w_rdata;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .i_clk  (iCLK),
        .i_we   (w_mem_we),
        .i_wstrb(w_strb),
        .i_addr (w_addr[AW+1:2]),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    assign oRAM_DATA = r_data;
    assign oRAM_DONE = r_done;
    assign oRAM_ERR  = r_err;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed scenarios with literal expectations plus randomized traffic.
// Latency: model predicts the done cycle from the accept edge and LATENCY.
// Backpressure: initiator holds CE until done, sometimes longer, sometimes drops it early.
module tb_ram_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        ce_i   = 1'b0;
    logic        rd_i   = 1'b0;
    logic        wr_i   = 1'b0;
    logic [3:0]  strb_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdat_i = 32'h0;
    logic [31:0] o_data;
    logic        o_done;
    logic        o_err;

    ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iRAM_CE   (ce_i),
        .iRAM_RD   (rd_i),
        .iRAM_WR   (wr_i),
        .iRAM_WSTRB(strb_i),
        .iRAM_ADDR (addr_i),
        .iRAM_DATA (wdat_i),
        .oRAM_DATA (o_data),
        .oRAM_DONE (o_done),
        .oRAM_ERR  (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        rd;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        pend[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] exp_data = 32'h0;
    int          cyc      = 0;
    int          n_chk    = 0;
    int          n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: each accepted access completes at its due cycle; reset discards pending work.
    always @(posedge clk) begin
        logic rs;
        logic e_done;
        logic e_err;
        acc_t a;
        int   idx;
        rs = rst;
        cyc++;
        #1;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rs) begin
            pend.delete();
            exp_data = 32'h0;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            a      = pend.pop_front();
            e_done = 1'b1;
            e_err  = (a.addr >= 32'(4 * DEPTH)) || (a.rd == a.wr);
            idx    = int'(a.addr / 4);
            if (!e_err && a.wr) begin
                for (int k = 0; k < 4; k++)
                    if (a.strb[k]) mdl_mem[idx][8*k +: 8] = a.data[8*k +: 8];
            end
            if (a.rd) exp_data = e_err ? 32'h0 : mdl_mem[idx];
        end
        check("done", {31'h0, o_done}, {31'h0, e_done});
        if (e_done || rs) check("err", {31'h0, o_err}, {31'h0, e_err});
        check("data", o_data, exp_data);
    end

    // One initiator transaction. Returns edges from accept to done, and the outputs seen with done.
    task automatic do_acc(input logic r, input logic w, input logic [3:0] s,
                          input logic [31:0] ad, input logic [31:0] d,
                          input int extra_hold, input bit drop_early,
                          output int lat, output logic [31:0] dseen, output logic eseen);
        int acc_cyc;
        int waited;
        @(negedge clk);
        rd_i = r; wr_i = w; strb_i = s; addr_i = ad; wdat_i = d; ce_i = 1'b1;
        acc_cyc = cyc + 1;
        pend.push_back('{cyc + 2 + LAT, r, w, s, ad, d});
        @(negedge clk);
        waited = 0;
        while (!o_done && waited < 40) begin
            rd_i   = 1'($urandom);
            wr_i   = 1'($urandom);
            strb_i = 4'($urandom);
            addr_i = $urandom;
            wdat_i = $urandom;
            if (drop_early) ce_i = 1'b0;
            @(negedge clk);
            waited++;
        end
        if (!o_done) begin
            check("done_timeout", 32'(waited), 32'(LAT + 1));
            lat = -1;
        end else begin
            lat = cyc - acc_cyc;
        end
        dseen = o_data;
        eseen = o_err;
        if (!drop_early) begin
            repeat (extra_hold) @(negedge clk);
        end
        ce_i = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] dv;
        logic        ev;
        logic        r;
        logic        w;
        logic [31:0] ad;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Known contents for words 0..15.
        for (int i = 0; i < 16; i++) begin
            do_acc(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom, 0, 1'b0, lat, dv, ev);
            check("init_lat", 32'(lat), 32'd3);
        end

        // Full write then read back.
        do_acc(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 1'b0, lat, dv, ev);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_err", {31'h0, ev}, 32'h0);
        do_acc(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, 1'b0, lat, dv, ev);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", dv, 32'hDEADBEEF);
        check("rd_err", {31'h0, ev}, 32'h0);

        // Partial strobe write.
        do_acc(1'b0, 1'b1, 4'b0101, 32'h10, 32'h11223344, 0, 1'b0, lat, dv, ev);
        do_acc(1'b1, 1'b0, 4'h0, 32'h13, 32'h0, 0, 1'b0, lat, dv, ev);
        check("strb_data", dv, 32'hDE22BE44);

        // Out of range read and write.
        do_acc(1'b0, 1'b1, 4'hF, 32'h0, 32'hA5A55A5A, 0, 1'b0, lat, dv, ev);
        do_acc(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 0, 1'b0, lat, dv, ev);
        check("oor_rd_err", {31'h0, ev}, 32'h1);
        check("oor_rd_data", dv, 32'h0);
        do_acc(1'b0, 1'b1, 4'hF, 32'h400, 32'h12345678, 0, 1'b0, lat, dv, ev);
        check("oor_wr_err", {31'h0, ev}, 32'h1);
        do_acc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, lat, dv, ev);
        check("oor_word0", dv, 32'hA5A55A5A);

        // CE held well past done: single pulse, then a normal follow-up access.
        do_acc(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 7, 1'b0, lat, dv, ev);
        check("hold_data", dv, 32'hDE22BE44);

        // Write of 0x0 to 0x20 (word 8), then a write aborted by reset one cycle after accept.
        do_acc(1'b0, 1'b1, 4'hF, 32'h20, 32'h0, 0, 1'b0, lat, dv, ev);
        @(negedge clk);
        rd_i = 1'b0; wr_i = 1'b1; strb_i = 4'hF; addr_i = 32'h20; wdat_i = 32'hCAFEF00D; ce_i = 1'b1;
        pend.push_back('{cyc + 2 + LAT, 1'b0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D});
        @(negedge clk);
        rst = 1'b1; ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_acc(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 0, 1'b0, lat, dv, ev);
        check("rst_abort_data", dv, 32'h0);

        // RD and WR together.
        do_acc(1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFFFFFF, 0, 1'b0, lat, dv, ev);
        check("rdwr_err", {31'h0, ev}, 32'h1);
        do_acc(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, 1'b0, lat, dv, ev);
        check("rdwr_mem", dv, 32'hDE22BE44);

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 7))
                0:       begin r = 1'b1; w = 1'b1; end
                1:       begin r = 1'b0; w = 1'b0; end
                2, 3, 4: begin r = 1'b1; w = 1'b0; end
                default: begin r = 1'b0; w = 1'b1; end
            endcase
            if ($urandom_range(0, 5) == 0) ad = 32'h400 | $urandom;
            else ad = 32'($urandom_range(0, 63));
            do_acc(r, w, 4'($urandom), ad, $urandom, $urandom_range(0, 3),
                   1'($urandom), lat, dv, ev);
            check("rand_lat", 32'(lat), 32'(LAT + 1));
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
